// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM states and fixed constants.
package md_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_CNT_W   = 5;
    localparam int MD_LATENCY = MD_WIDTH + 1;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_UMULL = 2'b01,
        MD_SMULL = 2'b10,
        MD_UDIV  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_t;

    localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/md_datapath.sv
// Shift-add multiply / restoring divide datapath. A double-width accumulator
// holds {hi, lo}; one iteration per step strobe, sign fix-up on finish.
module md_datapath
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             div0,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg;

    logic [2*WIDTH-1:0] step_val;
    logic [2*WIDTH-1:0] final_val;
    logic [WIDTH:0]     shifted_hi;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sum;
    logic               is_smull;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign is_smull = (md_op_t'(op) == MD_SMULL);
    assign mag_a    = (is_smull && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b    = (is_smull && src_b[WIDTH-1]) ? -src_b : src_b;

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        step_val   = acc;
        shifted_hi = acc[2*WIDTH-1:WIDTH-1];
        trial      = shifted_hi - {1'b0, opnd};
        sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        if (is_div) begin
            // Remainder stays below the divisor, so a non-negative trial fits in WIDTH bits.
            if (shifted_hi >= {1'b0, opnd})
                step_val = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                step_val = {shifted_hi[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step_val = {sum, acc[WIDTH-1:1]};
        end
        final_val = neg ? -step_val : step_val;
    end

    // NOTE: the working registers are always loaded before use, so they carry no reset; only the visible results do.
    always_ff @(posedge clk) begin
        if (load) begin
            acc    <= {{WIDTH{1'b0}}, mag_a};
            opnd   <= mag_b;
            is_div <= (md_op_t'(op) == MD_UDIV);
            neg    <= is_smull && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        end else if (step) begin
            acc <= step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_lo <= '0;
            result_hi <= '0;
        end else if (div0) begin
            result_lo <= DIV0_QUOT;
            result_hi <= src_a;
        end else if (finish) begin
            result_lo <= final_val[WIDTH-1:0];
            result_hi <= final_val[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage multiply/divide sequencer: IDLE/RUN/DONE control FSM that
// stalls the pipeline while md_datapath iterates, then pulses MdDoneE.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             AbortE,
    output logic             MdStallE,
    output logic             MdDoneE,
    output logic [WIDTH-1:0] ResultLoE,
    output logic [WIDTH-1:0] ResultHiE,
    output logic             WrHiE,
    output logic             BusyE
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q;
    md_op_t           op_q;

    logic load, step, finish, div0;

    assign load   = (state_q == IDLE) && StartE && !AbortE;
    assign div0   = load && (md_op_t'(OpE) == MD_UDIV) && (SrcBE == '0);
    assign step   = (state_q == RUN) && !AbortE;
    assign finish = step && (count_q == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= MD_MUL;
        end else begin
            state_q <= state_d;
            if (load) begin
                count_q <= '0;
                op_q    <= md_op_t'(OpE);
            end else if (step) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (AbortE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (StartE) state_d = div0 ? DONE : RUN;
                RUN:     if (finish) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        MdStallE = 1'b0;
        MdDoneE  = 1'b0;
        WrHiE    = 1'b0;
        BusyE    = (state_q != IDLE);
        unique case (state_q)
            IDLE: MdStallE = StartE;
            RUN:  MdStallE = 1'b1;
            DONE: begin
                MdDoneE = 1'b1;
                WrHiE   = (op_q == MD_UMULL) || (op_q == MD_SMULL);
            end
            default: ;
        endcase
    end

    md_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .div0      (div0),
        .op        (OpE),
        .src_a     (SrcAE),
        .src_b     (SrcBE),
        .result_lo (ResultLoE),
        .result_hi (ResultHiE)
    );

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed corner cases plus random
// ops compared against a 64-bit arithmetic reference model.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        AbortE;
    logic        MdStallE;
    logic        MdDoneE;
    logic [31:0] ResultLoE;
    logic [31:0] ResultHiE;
    logic        WrHiE;
    logic        BusyE;

    int n_checks = 0;
    int n_errors = 0;

    md_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .StartE    (StartE),
        .OpE       (OpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .AbortE    (AbortE),
        .MdStallE  (MdStallE),
        .MdDoneE   (MdDoneE),
        .ResultLoE (ResultLoE),
        .ResultHiE (ResultHiE),
        .WrHiE     (WrHiE),
        .BusyE     (BusyE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {wr_hi, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        wr;
        case (op)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; wr = 1'b0; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; wr = 1'b1; end
            2'b10: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; wr = 1'b1; end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
                wr = 1'b0;
            end
        endcase
        return {wr, p};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op at cycle T and checks stall window, done latency and results.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input string tag);
        logic [64:0] exp;
        int lat, stalls, exp_lat;
        bit done;
        exp     = model(op, a, b);
        exp_lat = (op == 2'b11 && b == 32'd0) ? 1 : MD_LATENCY;
        @(posedge clk); #1;
        StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
        @(negedge clk);
        check({tag, "_idle_at_T"}, BusyE, 1'b0);
        check({tag, "_stall_at_T"}, MdStallE, 1'b1);
        lat = 0; stalls = 1; done = 1'b0;
        for (int i = 0; i < MD_LATENCY + 8 && !done; i++) begin
            @(posedge clk); #1;
            if (!hold) StartE = 1'b0;
            lat++;
            @(negedge clk);
            if (MdDoneE) done = 1'b1;
            else if (MdStallE) stalls++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stall_cycles"}, stalls, exp_lat);
        check({tag, "_stall_in_done"}, MdStallE, 1'b0);
        check({tag, "_lo"}, ResultLoE, exp[31:0]);
        check({tag, "_hi"}, ResultHiE, exp[63:32]);
        check({tag, "_wrhi"}, WrHiE, exp[64]);
        if (!hold) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_done_pulse"}, MdDoneE, 1'b0);
            check({tag, "_back_idle"}, BusyE, 1'b0);
        end
    endtask

    task automatic start_and_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int cycles);
        @(posedge clk); #1;
        StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            StartE = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        bit          seen_done;

        reset = 1'b1; StartE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0; AbortE = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", MdStallE, 1'b0);
        check("rst_done", MdDoneE, 1'b0);
        check("rst_wrhi", WrHiE, 1'b0);
        check("rst_busy", BusyE, 1'b0);
        check("rst_lo", ResultLoE, 32'd0);
        check("rst_hi", ResultHiE, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umull_max");
        run_op(2'b10, 32'hFFFF_FFFE, 32'd3, 1'b0, "smull_neg");
        run_op(2'b00, 32'd7, 32'd6, 1'b0, "mul_7x6");
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "udiv_100_7");
        run_op(2'b11, 32'd5, 32'd0, 1'b0, "udiv_by0");
        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0, "smull_minmin");

        // StartE held through DONE must not retrigger; next op issued at T+34.
        run_op(2'b01, 32'd12345, 32'd678, 1'b1, "hold_first");
        run_op(2'b00, 32'd3, 32'd3, 1'b0, "hold_second");

        // Reset at RUN count 10.
        start_and_run(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 11);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", BusyE, 1'b0);
        check("midrst_stall", MdStallE, 1'b0);
        check("midrst_done", MdDoneE, 1'b0);
        check("midrst_lo", ResultLoE, 32'd0);
        check("midrst_hi", ResultHiE, 32'd0);

        // Abort at RUN count 20 leaves previous results intact.
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "pre_abort");
        start_and_run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 21);
        AbortE = 1'b1;
        @(negedge clk);
        check("abort_cycle_stall", MdStallE, 1'b1);
        @(posedge clk); #1;
        AbortE = 1'b0;
        @(negedge clk);
        check("abort_busy", BusyE, 1'b0);
        check("abort_stall", MdStallE, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MdDoneE) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 1'b0);
        check("abort_lo_kept", ResultLoE, 32'd14);
        check("abort_hi_kept", ResultHiE, 32'd2);

        for (int n = 0; n < 40; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick();
            r_b  = pick();
            run_op(r_op, r_a, r_b, 1'b0, $sformatf("rand%0d_op%0d", n, r_op));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Iterative multiply/divide sequencer for the Execute stage of the pipelined core. It accepts MUL, UMULL, SMULL and UDIV operations. While an operation runs it holds the pipeline through MdStallE, which the hazard unit ORs into its stall/flush equations. On completion it presents one or two results. The Hi result drives the second register-file write port (RegWrite2 path), so the existing forwarding paths need no change.

Parameters:
WIDTH, 32, operand width; results are WIDTH (Lo) and WIDTH (Hi)
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
StartE  input  1  valid md op in E (already qualified by CondExE)
OpE  input  2  00 MUL, 01 UMULL, 10 SMULL, 11 UDIV
SrcAE  input  WIDTH  multiplicand / dividend
SrcBE  input  WIDTH  multiplier / divisor
AbortE  input  1  kill in-flight op (exception/interrupt)
MdStallE  output  1  hold F/D/E, bubble M
MdDoneE  output  1  one-cycle result-valid pulse
ResultLoE  output  WIDTH  product[31:0] / quotient
ResultHiE  output  WIDTH  product[63:32] / remainder
WrHiE  output  1  Hi write enable; 1 only for UMULL/SMULL in DONE
BusyE  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (sync): state=IDLE, count=0, ResultLoE=ResultHiE=0. MdStallE, MdDoneE, WrHiE and BusyE are all 0.
- IDLE, StartE=1:
  - MdStallE=1 combinationally in the same cycle T.
  - Latch operands and op at the end of T.
  - Next state RUN with count=0.
  - Exception: UDIV with SrcBE==0 goes straight to DONE.
- IDLE, StartE=0: MdStallE=0, stay in IDLE.
- RUN:
  - MdStallE=1; one iteration per cycle; count increments.
  - At count==WIDTH-1, the final iteration completes and next state is DONE.
  - Timing: RUN occupies T+1..T+32 and DONE is T+33. MdStallE is high for 33 cycles (T..T+32).
- DONE:
  - MdStallE=0, MdDoneE=1, results valid. E advances at the end of this cycle.
  - Next state IDLE unconditionally.
  - StartE is ignored in DONE: it still reflects the completing instruction.
- Multiply:
  - Radix-2 shift-add on magnitudes, 64-bit accumulator.
  - SMULL takes absolute values at latch. If the operand signs differ, the result is two's-complement negated (64-bit) on the RUN→DONE edge.
  - MUL: Lo only, WrHiE=0.
- Divide:
  - Restoring, unsigned; one quotient bit per cycle.
  - Lo=quotient, Hi=remainder, WrHiE=0 (remainder not architecturally written).
  - Divide by zero: Lo=0xFFFFFFFF, Hi=dividend, DONE at T+1 (stall 1 cycle).
- AbortE:
  - Has priority over everything except reset.
  - In any state, next state IDLE. No MdDoneE pulse; results are not updated.
  - MdStallE drops in the cycle after abort.
- Reset mid-RUN: next cycle IDLE, all outputs as reset values.
- Results hold their value until the next DONE.

Decomposition:
- Package md_pkg:
  - Op encodings MD_MUL/MD_UMULL/MD_SMULL/MD_UDIV.
  - FSM state typedef (IDLE/RUN/DONE).
  - DIV0_QUOT constant (all ones).
  - MD_LATENCY = WIDTH+1.
- Sub-module md_datapath:
  - 64-bit accumulator/remainder register, shift-add/subtract step, sign fix-up.
  - Controlled by step/load/finish strobes from the md_sequencer FSM.

Test Plan:
- UMULL 0xFFFFFFFF×0xFFFFFFFF, StartE at T -> MdStallE high T..T+32; at T+33 MdDoneE=1, Hi=0xFFFFFFFE, Lo=0x00000001, WrHiE=1.
- SMULL 0xFFFFFFFE(−2)×3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, WrHiE=1.
- MUL 7×6 -> Lo=42, WrHiE=0; UDIV 100/7 -> Lo=14, Hi=2, WrHiE=0.
- UDIV 5/0 -> MdStallE high only at T, MdDoneE at T+1, Lo=0xFFFFFFFF, Hi=5.
- StartE held high through DONE, then a new MUL 3×3 at T+34 -> DONE cycle not re-triggered; second op DONE at T+67 with Lo=9.
- Reset at RUN count 10 -> next cycle IDLE, MdStallE=0, no MdDoneE; AbortE at count 20 -> same, results unchanged.
